// File: rtl/fp_max_pkg.sv
// Shared types and FP field helpers for the fp_max_reduce slice.
// Helpers take zero-extended fields plus the field widths, so any format up to 64 bits works.
package fp_max_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int STAT_NV = 4;
    localparam int STAT_DZ = 3;
    localparam int STAT_OF = 2;
    localparam int STAT_UF = 1;
    localparam int STAT_NX = 0;

    localparam int FW = 64;

    function automatic logic [FW-1:0] expo_ones(input int expo_w);
        return (FW'(1) << expo_w) - FW'(1);
    endfunction

    function automatic logic is_nan(input logic [FW-1:0] expo, input logic [FW-1:0] mant,
                                    input int expo_w);
        return (expo == expo_ones(expo_w)) && (mant != '0);
    endfunction

    // Signalling NaN: quiet bit (mantissa MSB) clear.
    function automatic logic is_snan(input logic [FW-1:0] expo, input logic [FW-1:0] mant,
                                     input int expo_w, input int mant_w);
        logic [FW-1:0] q;
        q = mant >> (mant_w - 1);
        return is_nan(expo, mant, expo_w) && !q[0];
    endfunction

    function automatic logic [FW-1:0] canonical_nan(input int expo_w, input int mant_w);
        return (expo_ones(expo_w) << mant_w) | (FW'(1) << (mant_w - 1));
    endfunction

endpackage

// File: rtl/fp_max_cmp.sv
// Combinational two-operand maxNum; a is the accumulator, b the incoming operand.
// Ties and NaN-vs-NaN keep a, so the earliest element wins.
module fp_max_cmp
    import fp_max_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] a,
    input  logic                            a_nan,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] b,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] res,
    output logic                            a_wins,
    output logic                            b_nan,
    output logic                            b_snan
);
    localparam int W = SIGN_W + EXPO_W + MANT_W;

    logic [FW-1:0] b_expo, b_mant;
    logic          b_gt_a;

    assign b_expo = FW'(b[MANT_W +: EXPO_W]);
    assign b_mant = FW'(b[MANT_W-1:0]);
    assign b_nan  = is_nan(b_expo, b_mant, EXPO_W);
    assign b_snan = is_snan(b_expo, b_mant, EXPO_W, MANT_W);

    // Sign-magnitude ordering; differing signs also give +0 > -0.
    always_comb begin
        b_gt_a = 1'b0;
        if (a[W-1] != b[W-1])
            b_gt_a = a[W-1];
        else if (!a[W-1])
            b_gt_a = b[W-2:0] > a[W-2:0];
        else
            b_gt_a = b[W-2:0] < a[W-2:0];
    end

    always_comb begin
        a_wins = 1'b1;
        res    = a;
        if (a_nan && b_nan) begin
            res = W'(canonical_nan(EXPO_W, MANT_W));
        end else if (a_nan) begin
            a_wins = 1'b0;
            res    = b;
        end else if (!b_nan && b_gt_a) begin
            a_wins = 1'b0;
            res    = b;
        end
    end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming FP maxNum reduction: one registered max/status/count per in_last-terminated packet.
// Define FP_MAX_INDEX_EN to add out_idx, the zero-based position of the winning element.
module fp_max_reduce
    import fp_max_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] out_data,
    output logic [4:0]                      out_status,
    output logic [CNT_W-1:0]                out_count
`ifdef FP_MAX_INDEX_EN
    ,
    output logic [CNT_W-1:0]                out_idx
`endif
);
    localparam int W = SIGN_W + EXPO_W + MANT_W;

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             acc_nan_q, acc_nan_d;
    logic             nv_q, nv_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [4:0]       out_status_q, out_status_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
`ifdef FP_MAX_INDEX_EN
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] out_idx_q, out_idx_d;
`endif

    logic [W-1:0] cmp_res;
    logic         cmp_a_wins, cmp_b_nan, cmp_b_snan;
    logic         beat, finish;

    fp_max_cmp #(.SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cmp (
        .a      (acc_q),
        .a_nan  (acc_nan_q),
        .b      (in_data),
        .res    (cmp_res),
        .a_wins (cmp_a_wins),
        .b_nan  (cmp_b_nan),
        .b_snan (cmp_b_snan)
    );

    assign beat = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_nan_d    = acc_nan_q;
        nv_d         = nv_q;
        count_d      = count_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        out_count_d  = out_count_q;
`ifdef FP_MAX_INDEX_EN
        idx_d        = idx_q;
        out_idx_d    = out_idx_q;
`endif
        finish       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d     = cmp_b_nan ? W'(canonical_nan(EXPO_W, MANT_W)) : in_data;
                    acc_nan_d = cmp_b_nan;
                    nv_d      = cmp_b_snan;
                    count_d   = CNT_W'(1);
`ifdef FP_MAX_INDEX_EN
                    idx_d     = '0;
`endif
                    state_d   = ST_ACC;
                    finish    = in_last;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_d     = cmp_res;
                    acc_nan_d = acc_nan_q && cmp_b_nan;
                    nv_d      = nv_q || cmp_b_snan;
                    count_d   = (&count_q) ? count_q : count_q + CNT_W'(1);
`ifdef FP_MAX_INDEX_EN
                    // Pre-increment count is this beat's position.
                    if (!cmp_a_wins)
                        idx_d = count_q;
`endif
                    finish    = in_last;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b0;
                    in_ready_d   = 1'b1;
                    acc_d        = '0;
                    acc_nan_d    = 1'b0;
                    nv_d         = 1'b0;
                    count_d      = '0;
                    out_status_d = '0;
`ifdef FP_MAX_INDEX_EN
                    idx_d        = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture results from the post-beat values so the last beat is included.
        if (finish) begin
            state_d      = ST_DONE;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            out_data_d   = acc_d;
            out_status_d = '0;
            out_status_d[STAT_NV] = nv_d;
            out_count_d  = count_d;
`ifdef FP_MAX_INDEX_EN
            out_idx_d    = idx_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            acc_nan_q    <= 1'b0;
            nv_q         <= 1'b0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= '0;
            out_count_q  <= '0;
`ifdef FP_MAX_INDEX_EN
            idx_q        <= '0;
            out_idx_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_nan_q    <= acc_nan_d;
            nv_q         <= nv_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
            out_count_q  <= out_count_d;
`ifdef FP_MAX_INDEX_EN
            idx_q        <= idx_d;
            out_idx_q    <= out_idx_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;
    assign out_count  = out_count_q;
`ifdef FP_MAX_INDEX_EN
    assign out_idx    = out_idx_q;
`endif

endmodule

// File: tb/tb_fp_max_reduce.sv
// Directed bench for fp_max_reduce (FP32 instance plus a CNT_W=2 instance for count saturation).
module tb_fp_max_reduce;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_status;
    logic [15:0] out_count;
`ifdef FP_MAX_INDEX_EN
    logic [15:0] out_idx;
    logic [1:0]  s_out_idx;
`endif

    logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [4:0]  s_out_status;
    logic [1:0]  s_out_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_max_reduce dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status), .out_count(out_count)
`ifdef FP_MAX_INDEX_EN
        , .out_idx(out_idx)
`endif
    );

    fp_max_reduce #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_status(s_out_status), .out_count(s_out_count)
`ifdef FP_MAX_INDEX_EN
        , .out_idx(s_out_idx)
`endif
    );

    // Drive one beat, wait (bounded) for acceptance; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Complete the output handshake (bounded).
    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL drain_timeout out_valid=%0b expected 1", out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        total++; if (out_status !== 5'h0) begin bad++; $display("FAIL rst_status got %b exp 0", out_status); end
        total++; if (out_count !== 16'd0) begin bad++; $display("FAIL rst_count got %0d exp 0", out_count); end
`ifdef FP_MAX_INDEX_EN
        total++; if (out_idx !== 16'd0) begin bad++; $display("FAIL rst_idx got %0d exp 0", out_idx); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send(32'h3F800000, 1'b0);
        send(32'hC0000000, 1'b0);
        in_valid = 1'b1; in_data = 32'h40600000; in_last = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %0b exp 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got %0b exp 1", out_valid); end
        total++; if (out_data !== 32'h40600000) begin bad++; $display("FAIL basic_data got %h exp 40600000", out_data); end
        total++; if (out_status !== 5'h0) begin bad++; $display("FAIL basic_status got %b exp 0", out_status); end
        total++; if (out_count !== 16'd3) begin bad++; $display("FAIL basic_count got %0d exp 3", out_count); end
`ifdef FP_MAX_INDEX_EN
        total++; if (out_idx !== 16'd2) begin bad++; $display("FAIL basic_idx got %0d exp 2", out_idx); end
`endif
        drain();
    endtask

    task automatic test_nan();
        send(32'h7FC00000, 1'b0);
        send(32'h3F800000, 1'b1);
        total++; if (out_data !== 32'h3F800000) begin bad++; $display("FAIL qnan_data got %h exp 3f800000", out_data); end
        total++; if (out_status !== 5'h0) begin bad++; $display("FAIL qnan_status got %b exp 0", out_status); end
`ifdef FP_MAX_INDEX_EN
        total++; if (out_idx !== 16'd1) begin bad++; $display("FAIL qnan_idx got %0d exp 1", out_idx); end
`endif
        drain();
        send(32'h7F800001, 1'b1);
        total++; if (out_data !== 32'h7FC00000) begin bad++; $display("FAIL snan_data got %h exp 7fc00000", out_data); end
        total++; if (out_status !== 5'b10000) begin bad++; $display("FAIL snan_status got %b exp 10000", out_status); end
        total++; if (out_count !== 16'd1) begin bad++; $display("FAIL snan_count got %0d exp 1", out_count); end
        drain();
    endtask

    task automatic test_zero_ties();
        send(32'h80000000, 1'b0);
        send(32'h00000000, 1'b1);
        total++; if (out_data !== 32'h00000000) begin bad++; $display("FAIL zero_nm_p got %h exp 00000000", out_data); end
        drain();
        send(32'h00000000, 1'b0);
        send(32'h80000000, 1'b1);
        total++; if (out_data !== 32'h00000000) begin bad++; $display("FAIL zero_p_nm got %h exp 00000000", out_data); end
        drain();
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        total++; if (out_data !== 32'h40000000) begin bad++; $display("FAIL tie_data got %h exp 40000000", out_data); end
`ifdef FP_MAX_INDEX_EN
        total++; if (out_idx !== 16'd0) begin bad++; $display("FAIL tie_idx got %0d exp 0", out_idx); end
`endif
        drain();
    endtask

    task automatic test_hold();
        send(32'h3F800000, 1'b1);
        in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc %0d got %0b exp 0", i, in_ready); end
            total++; if (out_data !== 32'h3F800000 || out_count !== 16'd1 || out_valid !== 1'b1) begin
                bad++; $display("FAIL hold_stable cyc %0d got %h/%0d/%0b exp 3f800000/1/1", i, out_data, out_count, out_valid);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release got valid=%0b ready=%0b exp 0/1", out_valid, in_ready);
        end
        total++; if (out_status !== 5'h0) begin bad++; $display("FAIL hold_status_clr got %b exp 0", out_status); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h40000000 || out_count !== 16'd1) begin
            bad++; $display("FAIL hold_next got %0b/%h/%0d exp 1/40000000/1", out_valid, out_data, out_count);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(32'h7F800001, 1'b0);
        send(32'h40000000, 1'b0);
        rst_n = 1'b0;
        #2;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_state got ready=%0b valid=%0b exp 1/0", in_ready, out_valid);
        end
        rst_n = 1'b1;
        send(32'hBF800000, 1'b1);
        total++; if (out_data !== 32'hBF800000) begin bad++; $display("FAIL midrst_data got %h exp bf800000", out_data); end
        total++; if (out_count !== 16'd1) begin bad++; $display("FAIL midrst_count got %0d exp 1", out_count); end
        total++; if (out_status !== 5'h0) begin bad++; $display("FAIL midrst_status got %b exp 0", out_status); end
        drain();
    endtask

    task automatic test_inf();
        send(32'hFF800000, 1'b0);
        send(32'h7F800000, 1'b1);
        total++; if (out_data !== 32'h7F800000) begin bad++; $display("FAIL inf_data got %h exp 7f800000", out_data); end
        total++; if (out_count !== 16'd2) begin bad++; $display("FAIL inf_count got %0d exp 2", out_count); end
        drain();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1; s_in_data = 32'h3F800000 + 32'(i); s_in_last = (i == 4);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        total++; if (s_out_valid !== 1'b1 || s_out_count !== 2'd3) begin
            bad++; $display("FAIL sat_count got valid=%0b count=%0d exp 1/3", s_out_valid, s_out_count);
        end
        total++; if (s_out_data !== 32'h3F800004) begin bad++; $display("FAIL sat_data got %h exp 3f800004", s_out_data); end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nan();
        test_zero_ties();
        test_hold();
        test_reset_mid();
        test_inf();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
